// File: rtl/spi_slave.sv
// SPI responder for a fixed-length, MSB-first frame (CS active-low, SCLK idle low).
// SCLK, MOSI and CS are oversampled in the clk_i domain. The received word is
// presented with a one-cycle strobe. A preloaded reply word is shifted out on
// MISO in the same frame.
module spi_slave #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic              cs_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] data_rx_bo,
  output logic              data_rx_wr_o,
  input  logic [DATA_W-1:0] data_tx_bi,
  input  logic              data_tx_wr_i,
  output logic              tx_pending_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_dly;
  logic                   cs_dly;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0]   data_rx_q, data_rx_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                tx_pend_q, tx_pend_d;
  logic                miso_q, miso_d;
  logic                rx_wr_q, rx_wr_d;
  logic                err_q, err_d;

  // Synchronise the SPI pins. CS resets low, so a frame already running at
  // reset release never produces a falling edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      cs_dly    <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign cs_rise   = cs_s & ~cs_dly;
  assign cs_fall   = ~cs_s & cs_dly;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_hold_q  <= '0;
      data_rx_q  <= '0;
      bit_cnt_q  <= '0;
      tx_pend_q  <= 1'b0;
      miso_q     <= 1'b0;
      rx_wr_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_hold_q  <= tx_hold_d;
      data_rx_q  <= data_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_pend_q  <= tx_pend_d;
      miso_q     <= miso_d;
      rx_wr_q    <= rx_wr_d;
      err_q      <= err_d;
    end
  end

  // Frame sequencing, shifting and the tx holding register.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_hold_d  = tx_hold_q;
    data_rx_d  = data_rx_q;
    bit_cnt_d  = bit_cnt_q;
    tx_pend_d  = tx_pend_q;
    miso_d     = miso_q;
    rx_wr_d    = 1'b0;
    err_d      = 1'b0;

    if (data_tx_wr_i) begin
      tx_hold_d = data_tx_bi;
      tx_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          // A write landing on the consume cycle is sent directly and not left pending.
          tx_shift_d = data_tx_wr_i ? data_tx_bi : tx_hold_q;
          tx_pend_d  = 1'b0;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          miso_d     = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (bit_cnt_q == CNT_FULL) begin
            data_rx_d = rx_shift_q;
            rx_wr_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_fall) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q != CNT_MAX) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso_o       = miso_q;
  assign miso_oe_o    = (state_q == ACTIVE);
  assign busy_o       = (state_q == ACTIVE);
  assign data_rx_bo   = data_rx_q;
  assign data_rx_wr_o = rx_wr_q;
  assign tx_pending_o = tx_pend_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: acts as the SPI master and checks every frame
// against a word-level model of holding register, reply and received data.
module tb_spi_slave;

  localparam int DW   = 32;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          sclk_i;
  logic          mosi_i;
  logic          cs_i;
  logic          miso_o;
  logic          miso_oe_o;
  logic [DW-1:0] data_rx_bo;
  logic          data_rx_wr_o;
  logic [DW-1:0] data_tx_bi;
  logic          data_tx_wr_i;
  logic          tx_pending_o;
  logic          busy_o;
  logic          frame_err_o;

  int checks = 0;
  int errors = 0;
  int rx_wr_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  logic [DW-1:0] m_hold;
  logic [DW-1:0] m_rx;
  logic          m_pend;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .sclk_i       (sclk_i),
    .mosi_i       (mosi_i),
    .cs_i         (cs_i),
    .miso_o       (miso_o),
    .miso_oe_o    (miso_oe_o),
    .data_rx_bo   (data_rx_bo),
    .data_rx_wr_o (data_rx_wr_o),
    .data_tx_bi   (data_tx_bi),
    .data_tx_wr_i (data_tx_wr_i),
    .tx_pending_o (tx_pending_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o)
  );

  // Count strobe cycles; a strobe wider than one cycle counts more than once.
  always @(posedge clk) begin
    if (data_rx_wr_o) rx_wr_cnt <= rx_wr_cnt + 1;
    if (frame_err_o)  err_cnt   <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wr_tx(input logic [DW-1:0] w);
    @(negedge clk);
    data_tx_bi   = w;
    data_tx_wr_i = 1'b1;
    @(negedge clk);
    data_tx_wr_i = 1'b0;
    m_hold = w;
    m_pend = 1'b1;
  endtask

  function automatic logic [63:0] reset_vec();
    return {25'd0, miso_o, miso_oe_o, busy_o, data_rx_wr_o, frame_err_o, tx_pending_o, data_rx_bo};
  endfunction

  // wr_at: -1 none, -2 on the cycle the frame consumes the holding register,
  // >=0 at the start of that bit. rst_at: bit at which reset is pulsed, -1 none.
  task automatic do_frame(input logic [DW-1:0] data, input int nbits, input int wr_at,
                          input logic [DW-1:0] wr_word, input int rst_at);
    int            rxc0;
    int            erc0;
    logic [DW-1:0] reply;
    logic [63:0]   got;
    logic [63:0]   exp;
    logic          b;
    bit            aborted;
    rxc0 = rx_wr_cnt;
    erc0 = err_cnt;
    aborted = (rst_at >= 0) && (rst_at < nbits);
    @(negedge clk);
    cs_i = 1'b0;
    if (wr_at == -2) begin
      @(negedge clk);
      @(negedge clk);
      data_tx_bi   = wr_word;
      data_tx_wr_i = 1'b1;
      @(negedge clk);
      data_tx_wr_i = 1'b0;
      m_hold = wr_word;
    end
    reply  = m_hold;
    m_pend = 1'b0;
    half_wait();
    check("busy_oe_in_frame", {62'd0, busy_o, miso_oe_o}, 64'd3);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk_i = 1'b1;
      mosi_i = (i < DW) ? data[DW-1-i] : 1'b0;
      if (i == rst_at) begin
        rst_n_i = 1'b0;
        #1;
        check("async_reset_outputs", reset_vec(), 64'd0);
        m_hold = '0;
        m_pend = 1'b0;
        m_rx   = '0;
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (HALF - 1) @(negedge clk);
      end else if (i == wr_at) begin
        data_tx_bi   = wr_word;
        data_tx_wr_i = 1'b1;
        @(negedge clk);
        data_tx_wr_i = 1'b0;
        m_hold = wr_word;
        m_pend = 1'b1;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        half_wait();
      end
      got = {got[62:0], miso_o};
      sclk_i = 1'b0;
      half_wait();
    end
    cs_i = 1'b1;
    half_wait();

    exp = '0;
    for (int i = 0; i < nbits; i++) begin
      if (aborted && i >= rst_at) b = 1'b0;
      else b = (i < DW) ? reply[DW-1-i] : 1'b0;
      exp = {exp[62:0], b};
    end
    check("miso_reply", got, exp);
    if (aborted) begin
      check("rx_strobes_aborted", 64'(rx_wr_cnt - rxc0), 64'd0);
      check("err_strobes_aborted", 64'(err_cnt - erc0), 64'd0);
    end else if (nbits == DW) begin
      m_rx = data;
      check("rx_strobes", 64'(rx_wr_cnt - rxc0), 64'd1);
      check("err_strobes", 64'(err_cnt - erc0), 64'd0);
    end else begin
      check("rx_strobes_bad_len", 64'(rx_wr_cnt - rxc0), 64'd0);
      check("err_strobes_bad_len", 64'(err_cnt - erc0), 64'd1);
    end
    check("data_rx", 64'(data_rx_bo), 64'(m_rx));
    check("tx_pending", 64'(tx_pending_o), 64'(m_pend));
    check("idle_after_frame", {61'd0, busy_o, miso_oe_o, miso_o}, 64'd0);
  endtask

  initial begin
    int            rxc0;
    int            erc0;
    int            nb;
    int            mode;
    logic [DW-1:0] w;
    rst_n_i      = 1'b0;
    sclk_i       = 1'b0;
    mosi_i       = 1'b0;
    cs_i         = 1'b1;
    data_tx_bi   = '0;
    data_tx_wr_i = 1'b0;
    m_hold = '0;
    m_rx   = '0;
    m_pend = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", reset_vec(), 64'd0);
    rst_n_i = 1'b1;
    repeat (5) @(negedge clk);

    // Basic full frame
    wr_tx(32'hA5A5_0F0F);
    check("pending_after_write", 64'(tx_pending_o), 64'd1);
    do_frame(32'h1234_5678, 32, -1, '0, -1);

    // Short and long frames
    do_frame($urandom, 16, -1, '0, -1);
    do_frame($urandom, 33, -1, '0, -1);

    // Back-to-back frames resend the same word
    wr_tx($urandom);
    do_frame($urandom, 32, -1, '0, -1);
    do_frame($urandom, 32, -1, '0, -1);

    // Mid-frame write goes to the next frame
    wr_tx(32'h0000_0001);
    do_frame($urandom, 32, 10, 32'hDEAD_BEEF, -1);
    do_frame($urandom, 32, -1, '0, -1);

    // Write on the consume cycle
    do_frame($urandom, 32, -2, $urandom, -1);

    // Reset in the middle of a frame, then a normal frame
    wr_tx($urandom);
    do_frame($urandom, 32, -1, '0, 10);
    do_frame($urandom, 32, -1, '0, -1);

    // SCLK activity with CS high is ignored
    rxc0 = rx_wr_cnt;
    erc0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      sclk_i = 1'b1;
      mosi_i = 1'($urandom);
      half_wait();
      sclk_i = 1'b0;
      half_wait();
      check("cs_high_idle", {62'd0, busy_o, miso_oe_o}, 64'd0);
    end
    check("cs_high_no_strobes", 64'(rx_wr_cnt - rxc0 + err_cnt - erc0), 64'd0);
    check("cs_high_data_rx", 64'(data_rx_bo), 64'(m_rx));

    // Randomised frames
    for (int f = 0; f < 20; f++) begin
      nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : DW;
      mode = int'($urandom_range(0, 3));
      w    = $urandom;
      if (mode == 1) wr_tx(w);
      if (mode == 2) do_frame($urandom, nb, -2, w, -1);
      else if (mode == 3) do_frame($urandom, nb, int'($urandom_range(0, nb - 1)), w, -1);
      else do_frame($urandom, nb, -1, '0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
